// File: rtl/mem_stage.sv
// Memory stage: issues the data-memory access for the EX/MEM instruction over a
// req/ack handshake, stalls upstream while it is outstanding, and loads MEM/WB.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_re_in,
  input  logic        mem_we_in,
  input  logic        reg_file_write_in,
  input  logic        branch_in,
  input  logic [1:0]  select_mux_2_in,
  input  logic [1:0]  select_mux_4_in,
  input  logic [31:0] reg_b_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] add_pc_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic        pcsrc_out,
  output logic [1:0]  select_mux_2_out,
  output logic [31:0] branch_target_out,
  output logic        reg_file_write_out,
  output logic [1:0]  select_mux_4_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_out,
  output logic [31:0] add_pc_out,
  output logic        mem_fault_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Value of the wait counter during the last WAIT cycle before the abort.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic [31:0] rbuf_q;
  logic        timeout_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic        wr_q;
  logic [1:0]  sel4_q;
  logic [31:0] rdata_q, alu_q, add_pc_q;
  logic        fault_q;

  logic access, illegal;

  assign access  = mem_re_in ^ mem_we_in;
  assign illegal = mem_re_in & mem_we_in;

  assign stall_out         = ((state_q == IDLE) && access) || (state_q == WAIT);
  assign pcsrc_out         = branch_in;
  assign select_mux_2_out  = select_mux_2_in;
  assign branch_target_out = add_pc_in;

  assign dmem_req           = req_q;
  assign dmem_we            = we_q;
  assign dmem_addr          = addr_q;
  assign dmem_wdata         = wdata_q;
  assign reg_file_write_out = wr_q;
  assign select_mux_4_out   = sel4_q;
  assign read_data_out      = rdata_q;
  assign alu_out            = alu_q;
  assign add_pc_out         = add_pc_q;
  assign mem_fault_out      = fault_q;

  // NOTE: state is updated with non-blocking assignments so every branch below
  // reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rbuf_q     <= '0;
      timeout_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      sel4_q     <= '0;
      rdata_q    <= '0;
      alu_q      <= '0;
      add_pc_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            req_q      <= 1'b1;
            we_q       <= mem_we_in;
            addr_q     <= alu_in;
            wdata_q    <= reg_b_in;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            wr_q       <= 1'b0;
            state_q    <= WAIT;
          end else begin
            // Illegal re&we still retires, but never writes the register file.
            wr_q     <= reg_file_write_in & ~illegal;
            sel4_q   <= select_mux_4_in;
            rdata_q  <= '0;
            alu_q    <= alu_in;
            add_pc_q <= add_pc_in;
            if (illegal) fault_q <= 1'b1;
          end
        end
        WAIT: begin
          wr_q <= 1'b0;
          if (dmem_ack) begin
            rbuf_q  <= we_q ? 32'h0 : dmem_rdata;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            if (wait_cnt_q == LAST_WAIT) begin
              req_q     <= 1'b0;
              we_q      <= 1'b0;
              rbuf_q    <= '0;
              timeout_q <= 1'b1;
              fault_q   <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          wr_q     <= reg_file_write_in & ~timeout_q;
          sel4_q   <= select_mux_4_in;
          rdata_q  <= rbuf_q;
          alu_q    <= alu_in;
          add_pc_q <= add_pc_in;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
